// File: rtl/alu_pipelined_if.sv
// Execute-stage ALU bus: command/operand handshake in, result/status handshake out.
interface alu_pipelined_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CMD_LEN = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [CMD_LEN-1:0] alu_command;
  logic [WIDTH-1:0]   alu_in1;
  logic [WIDTH-1:0]   alu_in2;
  logic [WIDTH-1:0]   alu_in3;
  logic               cin;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   alu_out;
  logic [3:0]         status_register;
  logic               busy;

  // Upstream/downstream side (pipeline control, ID/EXE and EXE/MEM registers)
  modport master (
    output in_valid, alu_command, alu_in1, alu_in2, alu_in3, cin, flush, out_ready,
    input  in_ready, out_valid, alu_out, status_register, busy
  );

  // ALU side
  modport slave (
    input  in_valid, alu_command, alu_in1, alu_in2, alu_in3, cin, flush, out_ready,
    output in_ready, out_valid, alu_out, status_register, busy
  );
endinterface

// File: rtl/alu_pipelined.sv
// Registered execute-stage ALU: single-cycle logic/add/sub, iterative MUL/MLA,
// valid/ready on both sides, {Z,C,N,V} status nibble.
module alu_pipelined #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1,
  parameter int unsigned CMD_LEN  = 4
) (
  input  logic           clk,
  input  logic           rst,
  alu_pipelined_if.slave bus
);

  localparam int unsigned ITER  = WIDTH / MUL_STEP;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  localparam logic [CMD_LEN-1:0] CMD_MOV = CMD_LEN'(4'b0001);
  localparam logic [CMD_LEN-1:0] CMD_MVN = CMD_LEN'(4'b1001);
  localparam logic [CMD_LEN-1:0] CMD_ADD = CMD_LEN'(4'b0010);
  localparam logic [CMD_LEN-1:0] CMD_ADC = CMD_LEN'(4'b0011);
  localparam logic [CMD_LEN-1:0] CMD_SUB = CMD_LEN'(4'b0100);
  localparam logic [CMD_LEN-1:0] CMD_SBC = CMD_LEN'(4'b0101);
  localparam logic [CMD_LEN-1:0] CMD_AND = CMD_LEN'(4'b0110);
  localparam logic [CMD_LEN-1:0] CMD_ORR = CMD_LEN'(4'b0111);
  localparam logic [CMD_LEN-1:0] CMD_EOR = CMD_LEN'(4'b1000);
  localparam logic [CMD_LEN-1:0] CMD_MUL = CMD_LEN'(4'b1010);
  localparam logic [CMD_LEN-1:0] CMD_MLA = CMD_LEN'(4'b1011);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cin_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] alu_out_q;
  logic [3:0]       status_q;
  logic             busy_q;

  logic             in_ready_c;
  logic             accept_c;
  logic             is_mul_c;
  logic [WIDTH-1:0] res_d;
  logic [3:0]       status_d;
  logic [WIDTH-1:0] acc_d;

  // Accept only when idle and the output register is free or draining this edge
  assign in_ready_c = ~rst & (state_q == ST_IDLE) & (~out_valid_q | bus.out_ready);
  assign accept_c   = bus.in_valid & in_ready_c;
  assign is_mul_c   = (bus.alu_command == CMD_MUL) | (bus.alu_command == CMD_MLA);

  assign bus.in_ready        = in_ready_c;
  assign bus.out_valid       = out_valid_q;
  assign bus.alu_out         = alu_out_q;
  assign bus.status_register = status_q;
  assign bus.busy            = busy_q;

  // Single-cycle datapath: result and flags; carries formed in WIDTH+1 bits
  always_comb begin
    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;
    logic [WIDTH:0] nb_x;
    logic [WIDTH:0] cin_x;
    logic [WIDTH:0] sum_x;
    logic           c_flag;
    logic           v_flag;
    a_x    = {1'b0, bus.alu_in1};
    b_x    = {1'b0, bus.alu_in2};
    nb_x   = {1'b0, ~bus.alu_in2};
    cin_x  = {{WIDTH{1'b0}}, bus.cin};
    sum_x  = '0;
    res_d  = '0;
    c_flag = bus.cin;
    v_flag = 1'b0;
    case (bus.alu_command)
      CMD_MOV: res_d = bus.alu_in2;
      CMD_MVN: res_d = ~bus.alu_in2;
      CMD_ADD, CMD_ADC: begin
        sum_x  = (bus.alu_command == CMD_ADC) ? (a_x + b_x + cin_x) : (a_x + b_x);
        res_d  = sum_x[WIDTH-1:0];
        c_flag = sum_x[WIDTH];
        v_flag = (bus.alu_in1[WIDTH-1] == bus.alu_in2[WIDTH-1]) &
                 (res_d[WIDTH-1] != bus.alu_in1[WIDTH-1]);
      end
      CMD_SUB, CMD_SBC: begin
        sum_x  = (bus.alu_command == CMD_SBC) ? (a_x + nb_x + cin_x)
                                              : (a_x + nb_x + (WIDTH+1)'(1));
        res_d  = sum_x[WIDTH-1:0];
        c_flag = sum_x[WIDTH];
        v_flag = (bus.alu_in1[WIDTH-1] != bus.alu_in2[WIDTH-1]) &
                 (res_d[WIDTH-1] != bus.alu_in1[WIDTH-1]);
      end
      CMD_AND: res_d = bus.alu_in1 & bus.alu_in2;
      CMD_ORR: res_d = bus.alu_in1 | bus.alu_in2;
      CMD_EOR: res_d = bus.alu_in1 ^ bus.alu_in2;
      CMD_MUL, CMD_MLA: res_d = '0;
      default: begin
        res_d  = '0;
        c_flag = 1'b0;
      end
    endcase
    status_d = {(res_d == '0), c_flag, res_d[WIDTH-1], v_flag};
  end

  // Shift-add step: add multiplicand for each multiplier bit retired this cycle
  always_comb begin
    logic [WIDTH-1:0] part;
    part = '0;
    for (int i = 0; i < int'(MUL_STEP); i++) begin
      if (b_q[i]) part = part + (a_q << i);
    end
    acc_d = acc_q + part;
  end

  // Control FSM and all output/working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      status_q    <= '0;
      busy_q      <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
          if (accept_c) begin
            if (is_mul_c) begin
              a_q     <= bus.alu_in1;
              b_q     <= bus.alu_in2;
              acc_q   <= (bus.alu_command == CMD_MLA) ? bus.alu_in3 : '0;
              cin_q   <= bus.cin;
              cnt_q   <= CNT_W'(ITER);
              busy_q  <= 1'b1;
              state_q <= ST_MUL;
            end else begin
              alu_out_q   <= res_d;
              status_q    <= status_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_q <= acc_d;
          a_q   <= a_q << MUL_STEP;
          b_q   <= b_q >> MUL_STEP;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          alu_out_q   <= acc_q;
          status_q    <= {(acc_q == '0), cin_q, acc_q[WIDTH-1], 1'b0};
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipelined.sv
// Directed bench for alu_pipelined: flags, multi-cycle multiply, backpressure, reset/flush abort.
module tb_alu_pipelined;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_pipelined_if #(.WIDTH(W), .CMD_LEN(4)) bus ();

  alu_pipelined #(.WIDTH(W), .MUL_STEP(1), .CMD_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c3, input logic ci);
    bus.alu_command = cmd;
    bus.alu_in1     = a;
    bus.alu_in2     = b;
    bus.alu_in3     = c3;
    bus.cin         = ci;
    bus.in_valid    = 1'b1;
  endtask

  // Present one command for one edge, then return 1 time unit after that edge
  task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c3, input logic ci);
    drive(cmd, a, b, c3, ci);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.alu_out !== 32'h0) begin n_err++; $display("FAIL reset_alu_out: got %h want 0", bus.alu_out); end
    n_cmp++; if (bus.status_register !== 4'b0000) begin n_err++; $display("FAIL reset_status: got %b want 0000", bus.status_register); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add;
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.alu_out !== 32'h8000_0000) begin n_err++; $display("FAIL add_result: got %h want 80000000", bus.alu_out); end
    n_cmp++; if (bus.status_register !== 4'b0011) begin n_err++; $display("FAIL add_status: got %b want 0011", bus.status_register); end
    issue(4'b0011, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {32'h0, 4'b1100}) begin n_err++; $display("FAIL adc_wrap: got %h/%b want 0/1100", bus.alu_out, bus.status_register); end
  endtask

  task automatic test_sub;
    issue(4'b0100, 32'h5, 32'h5, 32'h0, 1'b0);
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {32'h0, 4'b1100}) begin n_err++; $display("FAIL sub_eq: got %h/%b want 0/1100", bus.alu_out, bus.status_register); end
    issue(4'b0100, 32'h100, 32'h100, 32'h0, 1'b0);
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {32'h0, 4'b1100}) begin n_err++; $display("FAIL sub_eq_wide: got %h/%b want 0/1100", bus.alu_out, bus.status_register); end
    issue(4'b0100, 32'h8000_0000, 32'h1, 32'h0, 1'b0);
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {32'h7FFF_FFFF, 4'b0101}) begin n_err++; $display("FAIL sub_ovf: got %h/%b want 7fffffff/0101", bus.alu_out, bus.status_register); end
  endtask

  task automatic test_sbc;
    issue(4'b0101, 32'h3, 32'h5, 32'h0, 1'b1);
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {32'hFFFF_FFFE, 4'b0010}) begin n_err++; $display("FAIL sbc_cin1: got %h/%b want fffffffe/0010", bus.alu_out, bus.status_register); end
    issue(4'b0101, 32'h3, 32'h5, 32'h0, 1'b0);
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {32'hFFFF_FFFD, 4'b0010}) begin n_err++; $display("FAIL sbc_cin0: got %h/%b want fffffffd/0010", bus.alu_out, bus.status_register); end
  endtask

  task automatic test_logic;
    issue(4'b1001, 32'h1234, 32'h0, 32'hDEAD, 1'b1);
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {32'hFFFF_FFFF, 4'b0110}) begin n_err++; $display("FAIL mvn: got %h/%b want ffffffff/0110", bus.alu_out, bus.status_register); end
    issue(4'b0110, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0, 1'b0);
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {32'h0000_00F0, 4'b0000}) begin n_err++; $display("FAIL and: got %h/%b want 000000f0/0000", bus.alu_out, bus.status_register); end
    issue(4'b1000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 1'b1);
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {32'h0, 4'b1100}) begin n_err++; $display("FAIL eor: got %h/%b want 0/1100", bus.alu_out, bus.status_register); end
    issue(4'b0001, 32'h0, 32'h8000_0001, 32'h0, 1'b0);
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {32'h8000_0001, 4'b0010}) begin n_err++; $display("FAIL mov: got %h/%b want 80000001/0010", bus.alu_out, bus.status_register); end
    issue(4'b1111, 32'h55, 32'h66, 32'h0, 1'b1);
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {32'h0, 4'b1000}) begin n_err++; $display("FAIL illegal_cmd: got %h/%b want 0/1000", bus.alu_out, bus.status_register); end
  endtask

  task automatic run_mul(input logic [3:0] cmd, input logic [W-1:0] c3, input logic ci,
                         input logic [W-1:0] exp_r, input logic [3:0] exp_s);
    int n;
    int busy_cnt;
    int rdy_cnt;
    n = 0; busy_cnt = 0; rdy_cnt = 0;
    issue(cmd, 32'd7, 32'd6, c3, ci);
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.in_ready !== 1'b0) rdy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL mul_latency: got %0d want 33", n); end
    n_cmp++; if (busy_cnt !== 32) begin n_err++; $display("FAIL mul_busy_cycles: got %0d want 32", busy_cnt); end
    n_cmp++; if (rdy_cnt !== 0) begin n_err++; $display("FAIL mul_in_ready_low: got %0d ready cycles want 0", rdy_cnt); end
    n_cmp++; if ({bus.alu_out, bus.status_register} !== {exp_r, exp_s}) begin n_err++; $display("FAIL mul_result: got %h/%b want %h/%b", bus.alu_out, bus.status_register, exp_r, exp_s); end
  endtask

  task automatic test_mul;
    run_mul(4'b1010, 32'd99, 1'b0, 32'd42, 4'b0000);
    run_mul(4'b1011, 32'd10, 1'b1, 32'd52, 4'b0100);
  endtask

  task automatic test_back_to_back;
    drive(4'b0010, 32'd1, 32'd100, 32'h0, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if ({bus.out_valid, bus.alu_out} !== {1'b1, 32'd101}) begin n_err++; $display("FAIL b2b_first: got %b/%0d want 1/101", bus.out_valid, bus.alu_out); end
    bus.out_ready = 1'b0;
    drive(4'b0010, 32'd2, 32'd100, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++; if ({bus.out_valid, bus.in_ready, bus.alu_out} !== {1'b1, 1'b0, 32'd101}) begin n_err++; $display("FAIL b2b_hold%0d: got v=%b r=%b %0d want v=1 r=0 101", k, bus.out_valid, bus.in_ready, bus.alu_out); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_release: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    n_cmp++; if ({bus.out_valid, bus.alu_out} !== {1'b1, 32'd102}) begin n_err++; $display("FAIL b2b_second: got %b/%0d want 1/102", bus.out_valid, bus.alu_out); end
    drive(4'b0010, 32'd3, 32'd100, 32'h0, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if ({bus.out_valid, bus.alu_out} !== {1'b1, 32'd103}) begin n_err++; $display("FAIL b2b_third: got %b/%0d want 1/103", bus.out_valid, bus.alu_out); end
    drive(4'b0010, 32'd4, 32'd100, 32'h0, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if ({bus.out_valid, bus.alu_out} !== {1'b1, 32'd104}) begin n_err++; $display("FAIL b2b_fourth: got %b/%0d want 1/104", bus.out_valid, bus.alu_out); end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
  endtask

  // Abort a multiply at its 10th cycle with reset (use_rst=1) or flush
  task automatic test_abort(input logic use_rst);
    int stale;
    stale = 0;
    issue(4'b1010, 32'd7, 32'd6, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.flush = 1'b0;
    #1;
    n_cmp++; if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin n_err++; $display("FAIL abort_%s_state: got v=%b busy=%b rdy=%b want 0/0/1", use_rst ? "rst" : "flush", bus.out_valid, bus.busy, bus.in_ready); end
    if (use_rst) begin
      n_cmp++; if (bus.alu_out !== 32'h0) begin n_err++; $display("FAIL abort_rst_out: got %h want 0", bus.alu_out); end
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL abort_%s_stale: got %0d active cycles want 0", use_rst ? "rst" : "flush", stale); end
  endtask

  task automatic test_flush_drop;
    drive(4'b0001, 32'h0, 32'hCAFE, 32'h0, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop: got %b want 0", bus.out_valid); end
    issue(4'b0001, 32'h0, 32'hBEEF, 32'h0, 1'b0);
    n_cmp++; if ({bus.out_valid, bus.alu_out} !== {1'b1, 32'hBEEF}) begin n_err++; $display("FAIL flush_recover: got %b/%h want 1/beef", bus.out_valid, bus.alu_out); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.alu_command = 4'b0000;
    bus.alu_in1 = '0;
    bus.alu_in2 = '0;
    bus.alu_in3 = '0;
    bus.cin = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    test_reset;
    test_add;
    test_sub;
    test_sbc;
    test_logic;
    test_mul;
    test_back_to_back;
    test_abort(1'b1);
    test_abort(1'b0);
    test_flush_drop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
